segre_lsu_stage: RTL

Parametrised load/store memory stage with an integrated SB_DEPTH-entry store buffer and a blocking load unit. It sits between the ALU/TL stage and writeback and owns the single data-cache port. Stores retire into the store buffer in one cycle and drain to the cache in the background. Loads forward from the buffer when fully covered, otherwise read the cache; results are sign- or zero-extended for writeback.

---
 rtl/segre_lsu_stage_if.sv | 48 ++++
 rtl/segre_lsu_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/segre_lsu_stage_if.sv
// Request, writeback, data-cache and flush signals of the segre LSU stage.
// slave is the LSU side, master is the pipeline/cache side.
interface segre_lsu_stage_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_rd_i;
  logic              req_wr_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_type_i;
  logic              req_sign_ext_i;
  logic [31:0]       req_wdata_i;
  logic [4:0]        req_rf_waddr_i;
  logic [ID_W-1:0]   req_id_i;
  logic              wb_valid_o;
  logic [31:0]       wb_data_o;
  logic [4:0]        wb_rf_waddr_o;
  logic [ID_W-1:0]   wb_id_o;
  logic              misalign_o;
  logic              dc_req_o;
  logic              dc_we_o;
  logic [ADDR_W-1:0] dc_addr_o;
  logic [3:0]        dc_be_o;
  logic [31:0]       dc_wdata_o;
  logic              dc_gnt_i;
  logic              dc_rvalid_i;
  logic [31:0]       dc_rdata_i;
  logic              sb_flush_i;
  logic              sb_empty_o;

  modport slave (
    input  req_valid_i, req_rd_i, req_wr_i, req_addr_i, req_type_i, req_sign_ext_i,
           req_wdata_i, req_rf_waddr_i, req_id_i, dc_gnt_i, dc_rvalid_i, dc_rdata_i,
           sb_flush_i,
    output req_ready_o, wb_valid_o, wb_data_o, wb_rf_waddr_o, wb_id_o, misalign_o,
           dc_req_o, dc_we_o, dc_addr_o, dc_be_o, dc_wdata_o, sb_empty_o
  );

  modport master (
    output req_valid_i, req_rd_i, req_wr_i, req_addr_i, req_type_i, req_sign_ext_i,
           req_wdata_i, req_rf_waddr_i, req_id_i, dc_gnt_i, dc_rvalid_i, dc_rdata_i,
           sb_flush_i,
    input  req_ready_o, wb_valid_o, wb_data_o, wb_rf_waddr_o, wb_id_o, misalign_o,
           dc_req_o, dc_we_o, dc_addr_o, dc_be_o, dc_wdata_o, sb_empty_o
  );
endinterface

// File: rtl/segre_lsu_stage.sv
// Load/store stage with SB_DEPTH-entry store buffer and blocking load unit on one cache port.
// Define SEGRE_SB_FWD_EN to enable store-to-load forwarding from the buffer.
module segre_lsu_stage #(
  parameter int ADDR_W   = 32,
  parameter int ID_W     = 4,
  parameter int SB_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rsn_i,
  segre_lsu_stage_if.slave bus
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [1:0] T_BYTE = 2'd0;
  localparam logic [1:0] T_HALF = 2'd1;
  localparam logic [1:0] T_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, DRAIN_WAIT} state_t;

  state_t state, state_next;

  logic [WA_W-1:0]  sb_addr [SB_DEPTH];
  logic [3:0]       sb_be   [SB_DEPTH];
  logic [31:0]      sb_data [SB_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count, count_next;
  logic             flushing, sb_empty, sb_full;

  logic [WA_W-1:0] ld_waddr;
  logic [1:0]      ld_off, ld_type;
  logic [3:0]      ld_mask;
  logic            ld_sext;
  logic [4:0]      ld_rf;
  logic [ID_W-1:0] ld_id;

  logic            wb_vld_p1, mis_vld_p1;
  logic [31:0]     wb_data_p1;
  logic [4:0]      wb_rf_p1;
  logic [ID_W-1:0] wb_id_p1;

  logic            ready, accept, req_mis, ld_acc, st_acc, push, pop;
  logic            rd_sel, drain_sel, fwd_wb, rd_done;
  logic [3:0]      req_mask;
  logic [WA_W-1:0] srch_waddr;
  logic            any_match;
  logic [3:0]      fwd_be;
  logic [31:0]     fwd_data;

  function automatic logic [3:0] byte_mask(input logic [1:0] typ, input logic [1:0] off);
    case (typ)
      T_BYTE:  byte_mask = 4'b0001 << off;
      T_HALF:  byte_mask = 4'b0011 << off;
      default: byte_mask = 4'hF;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] typ, input logic [1:0] off);
    misaligned = ((typ == T_HALF) && off[0]) || ((typ == T_WORD) && (off != 2'b00));
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [1:0] typ, input logic sext);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (typ)
      T_BYTE:  extract = {{24{sext & sh[7]}}, sh[7:0]};
      T_HALF:  extract = {{16{sext & sh[15]}}, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  assign sb_full  = (count == (PTR_W+1)'(SB_DEPTH));
  assign ready    = (state == IDLE) && !flushing && !sb_full && !rsn_i;
  assign accept   = bus.req_valid_i && ready;
  assign req_mask = byte_mask(bus.req_type_i, bus.req_addr_i[1:0]);
  assign req_mis  = misaligned(bus.req_type_i, bus.req_addr_i[1:0]);
  assign ld_acc   = accept && bus.req_rd_i && !req_mis;
  assign st_acc   = accept && bus.req_wr_i && !req_mis;
  assign push     = st_acc;

  // A full or flushing buffer takes the port ahead of a waiting load read.
  assign rd_sel    = (state == RD_REQ) && !((sb_full || flushing) && (count != '0));
  assign drain_sel = !rd_sel && (count != '0);
  assign pop       = drain_sel && bus.dc_gnt_i;
  assign rd_done   = (state == RD_WAIT) && bus.dc_rvalid_i;

  assign srch_waddr = (state == IDLE) ? bus.req_addr_i[ADDR_W-1:2] : ld_waddr;

  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    any_match = 1'b0;
    fwd_be    = '0;
    fwd_data  = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = tail - PTR_W'(k + 1);
      if (((PTR_W+1)'(k) < count) && (sb_addr[idx] == srch_waddr)) begin
        if (!any_match) begin
          fwd_be   = sb_be[idx];
          fwd_data = sb_data[idx];
        end
        any_match = 1'b1;
      end
    end
  end

`ifdef SEGRE_SB_FWD_EN
  assign fwd_wb = ld_acc && any_match && ((fwd_be & req_mask) == req_mask);
`else
  assign fwd_wb = 1'b0;
`endif

  always_comb begin
    state_next = state;
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
    case (state)
      IDLE: begin
        if (ld_acc && !fwd_wb) state_next = any_match ? DRAIN_WAIT : RD_REQ;
      end
      RD_REQ:     if (rd_sel && bus.dc_gnt_i) state_next = RD_WAIT;
      RD_WAIT:    if (bus.dc_rvalid_i) state_next = IDLE;
      DRAIN_WAIT: if (!any_match) state_next = RD_REQ;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.dc_req_o   = 1'b0;
    bus.dc_we_o    = 1'b0;
    bus.dc_addr_o  = '0;
    bus.dc_be_o    = '0;
    bus.dc_wdata_o = '0;
    if (rd_sel) begin
      bus.dc_req_o  = 1'b1;
      bus.dc_addr_o = {ld_waddr, 2'b00};
      bus.dc_be_o   = ld_mask;
    end else if (drain_sel) begin
      bus.dc_req_o   = 1'b1;
      bus.dc_we_o    = 1'b1;
      bus.dc_addr_o  = {sb_addr[head], 2'b00};
      bus.dc_be_o    = sb_be[head];
      bus.dc_wdata_o = sb_data[head];
    end
  end

  // p0 -> p1: control state and writeback registers
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      flushing   <= 1'b0;
      sb_empty   <= 1'b1;
      wb_vld_p1  <= 1'b0;
      mis_vld_p1 <= 1'b0;
      wb_data_p1 <= '0;
      wb_rf_p1   <= '0;
      wb_id_p1   <= '0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      flushing   <= bus.sb_flush_i || (flushing && (count_next != '0));
      sb_empty   <= (count_next == '0);
      mis_vld_p1 <= accept && req_mis;
      wb_vld_p1  <= fwd_wb || rd_done;
      if (fwd_wb) begin
        wb_data_p1 <= extract(fwd_data, bus.req_addr_i[1:0], bus.req_type_i, bus.req_sign_ext_i);
        wb_rf_p1   <= bus.req_rf_waddr_i;
        wb_id_p1   <= bus.req_id_i;
      end else if (rd_done) begin
        wb_data_p1 <= extract(bus.dc_rdata_i, ld_off, ld_type, ld_sext);
        wb_rf_p1   <= ld_rf;
        wb_id_p1   <= ld_id;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      sb_addr[tail] <= bus.req_addr_i[ADDR_W-1:2];
      sb_be[tail]   <= req_mask;
      sb_data[tail] <= bus.req_wdata_i << {bus.req_addr_i[1:0], 3'b000};
    end
    if (ld_acc) begin
      ld_waddr <= bus.req_addr_i[ADDR_W-1:2];
      ld_off   <= bus.req_addr_i[1:0];
      ld_type  <= bus.req_type_i;
      ld_mask  <= req_mask;
      ld_sext  <= bus.req_sign_ext_i;
      ld_rf    <= bus.req_rf_waddr_i;
      ld_id    <= bus.req_id_i;
    end
  end

  assign bus.req_ready_o   = ready;
  assign bus.wb_valid_o    = wb_vld_p1;
  assign bus.wb_data_o     = wb_data_p1;
  assign bus.wb_rf_waddr_o = wb_rf_p1;
  assign bus.wb_id_o       = wb_id_p1;
  assign bus.misalign_o    = mis_vld_p1;
  assign bus.sb_empty_o    = sb_empty;
endmodule
